// File: rtl/control_unit.sv
// control_unit: fetch/decode/execute controller driving Data_Path; define CONTROL_UNIT_JUMP_EN to enable the JUMP opcode
module control_unit #(
  parameter int PC_WIDTH = 7
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic [15:0]         Instr,
  output logic [PC_WIDTH-1:0] PC_out,
  output logic [15:0]         IR_out,
  output logic [3:0]          State_out,
  output logic [7:0]          D_addr,
  output logic                D_wr,
  output logic                MuxSel,
  output logic [2:0]          ALU_s,
  output logic [3:0]          RF_A_Addr,
  output logic [3:0]          RF_B_Addr,
  output logic                RFWen,
  output logic [3:0]          RFWAddr
);
  typedef enum logic [3:0] {
    INIT   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    LOAD_A = 4'd3,
    LOAD_B = 4'd4,
    STORE  = 4'd5,
    ADD    = 4'd6,
    SUB    = 4'd7,
    HALT   = 4'd8
`ifdef CONTROL_UNIT_JUMP_EN
    , JUMP = 4'd9
`endif
  } state_t;
  state_t              r_state;
  state_t              w_next;
  logic [PC_WIDTH-1:0] r_pc;
  logic [15:0]         r_ir;
  logic [3:0]          w_op;
  assign w_op      = r_ir[15:12];
  assign PC_out    = r_pc;
  assign IR_out    = r_ir;
  assign State_out = r_state;
  // state, PC and IR registers; IR/PC update only in FETCH, JUMP reloads PC
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= INIT;
      r_pc    <= '0;
      r_ir    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == FETCH) begin
        r_ir <= Instr;
        r_pc <= r_pc + 1'b1;
      end
`ifdef CONTROL_UNIT_JUMP_EN
      if (r_state == JUMP) r_pc <= r_ir[PC_WIDTH-1:0];
`endif
    end
  end
  // next-state sequencing; unknown opcodes fall back to FETCH like NOOP
  always_comb begin
    w_next = FETCH;
    case (r_state)
      INIT:   w_next = FETCH;
      FETCH:  w_next = DECODE;
      DECODE: begin
        case (w_op)
          4'h1:    w_next = STORE;
          4'h2:    w_next = LOAD_A;
          4'h3:    w_next = ADD;
          4'h4:    w_next = SUB;
          4'h5:    w_next = HALT;
`ifdef CONTROL_UNIT_JUMP_EN
          4'h6:    w_next = JUMP;
`endif
          default: w_next = FETCH;
        endcase
      end
      LOAD_A: w_next = LOAD_B;
      HALT:   w_next = HALT;
`ifdef CONTROL_UNIT_JUMP_EN
      JUMP:   w_next = INIT;
`endif
      default: w_next = FETCH;
    endcase
  end
  // Moore control outputs decoded from state and IR fields
  always_comb begin
    D_addr    = '0;
    D_wr      = 1'b0;
    MuxSel    = 1'b0;
    ALU_s     = '0;
    RF_A_Addr = '0;
    RF_B_Addr = '0;
    RFWen     = 1'b0;
    RFWAddr   = '0;
    case (r_state)
      LOAD_A, LOAD_B: begin
        D_addr  = r_ir[7:0];
        RFWAddr = r_ir[11:8];
        MuxSel  = 1'b1;
        RFWen   = r_state == LOAD_B;
      end
      STORE: begin
        D_addr    = r_ir[7:0];
        RF_A_Addr = r_ir[11:8];
        D_wr      = 1'b1;
      end
      ADD, SUB: begin
        RFWAddr   = r_ir[11:8];
        RF_A_Addr = r_ir[7:4];
        RF_B_Addr = r_ir[3:0];
        ALU_s     = r_state == SUB ? 3'd2 : 3'd1;
        RFWen     = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: scoreboard bench for control_unit with a synchronous-read instruction ROM
module tb_control_unit;
  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [15:0] Instr;
  logic [6:0]  PC_out;
  logic [15:0] IR_out;
  logic [3:0]  State_out;
  logic [7:0]  D_addr;
  logic        D_wr;
  logic        MuxSel;
  logic [2:0]  ALU_s;
  logic [3:0]  RF_A_Addr;
  logic [3:0]  RF_B_Addr;
  logic        RFWen;
  logic [3:0]  RFWAddr;
  logic [15:0] rom [128];
  logic [52:0] q [$];
  logic [52:0] obs;
  logic [52:0] e;
  int checks = 0;
  int errors = 0;

  control_unit #(.PC_WIDTH(7)) dut (
    .Clk(Clk), .Rst(Rst), .Instr(Instr), .PC_out(PC_out), .IR_out(IR_out),
    .State_out(State_out), .D_addr(D_addr), .D_wr(D_wr), .MuxSel(MuxSel),
    .ALU_s(ALU_s), .RF_A_Addr(RF_A_Addr), .RF_B_Addr(RF_B_Addr),
    .RFWen(RFWen), .RFWAddr(RFWAddr)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) Instr <= rom[PC_out];
  assign obs = {State_out, PC_out, IR_out, D_addr, D_wr, MuxSel, ALU_s, RF_A_Addr, RF_B_Addr, RFWen, RFWAddr};

  function automatic logic [52:0] ex(input int st, input int pc, input int ir, input int da,
                                     input int dw, input int mx, input int al, input int ra,
                                     input int rb, input int we, input int wa);
    ex = {st[3:0], pc[6:0], ir[15:0], da[7:0], dw[0], mx[0], al[2:0], ra[3:0], rb[3:0], we[0], wa[3:0]};
  endfunction

  function automatic logic [52:0] fx(input int st, input int pc, input int ir);
    fx = ex(st, pc, ir, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_rom();
    q.push_back(fx(0, 0, 0));
    q.push_back(fx(0, 0, 0));
    q.push_back(fx(1, 0, 0));
    q.push_back(fx(2, 1, 0));
    q.push_back(fx(1, 1, 0));
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk); #1;
      e = q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reset c%0d: got %h want %h", i, obs, e);
      end
      if (i == 1) Rst = 1'b0;
    end
  endtask

  task automatic test_load();
    clear_rom();
    rom[0] = 16'h2C06;
    rom[1] = 16'h5000;
    do_reset();
    q.push_back(fx(1, 0, 0));
    q.push_back(fx(2, 1, 16'h2C06));
    q.push_back(ex(3, 1, 16'h2C06, 6, 0, 1, 0, 0, 0, 0, 12));
    q.push_back(ex(4, 1, 16'h2C06, 6, 0, 1, 0, 0, 0, 1, 12));
    q.push_back(fx(1, 1, 16'h2C06));
    q.push_back(fx(2, 2, 16'h5000));
    q.push_back(fx(8, 2, 16'h5000));
    for (int i = 0; i < 7; i++) begin
      @(posedge Clk); #1;
      e = q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL load c%0d: got %h want %h", i, obs, e);
      end
    end
  endtask

  task automatic test_add_sub();
    clear_rom();
    rom[0] = 16'h36C6;
    rom[1] = 16'h46C6;
    rom[2] = 16'h5000;
    do_reset();
    q.push_back(fx(1, 0, 0));
    q.push_back(fx(2, 1, 16'h36C6));
    q.push_back(ex(6, 1, 16'h36C6, 0, 0, 0, 1, 12, 6, 1, 6));
    q.push_back(fx(1, 1, 16'h36C6));
    q.push_back(fx(2, 2, 16'h46C6));
    q.push_back(ex(7, 2, 16'h46C6, 0, 0, 0, 2, 12, 6, 1, 6));
    q.push_back(fx(1, 2, 16'h46C6));
    q.push_back(fx(2, 3, 16'h5000));
    q.push_back(fx(8, 3, 16'h5000));
    for (int i = 0; i < 9; i++) begin
      @(posedge Clk); #1;
      e = q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL add_sub c%0d: got %h want %h", i, obs, e);
      end
    end
  endtask

  task automatic test_store_halt();
    clear_rom();
    rom[0] = 16'h1C0D;
    rom[1] = 16'h5000;
    do_reset();
    q.push_back(fx(1, 0, 0));
    q.push_back(fx(2, 1, 16'h1C0D));
    q.push_back(ex(5, 1, 16'h1C0D, 13, 1, 0, 0, 12, 0, 0, 0));
    q.push_back(fx(1, 1, 16'h1C0D));
    q.push_back(fx(2, 2, 16'h5000));
    for (int i = 0; i < 21; i++) q.push_back(fx(8, 2, 16'h5000));
    for (int i = 0; i < 26; i++) begin
      @(posedge Clk); #1;
      e = q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL store_halt c%0d: got %h want %h", i, obs, e);
      end
    end
  endtask

  task automatic test_jump();
    int n;
    clear_rom();
    rom[3] = 16'h6001;
    rom[4] = 16'h5000;
    do_reset();
    q.push_back(fx(1, 0, 0));
    q.push_back(fx(2, 1, 0));
    q.push_back(fx(1, 1, 0));
    q.push_back(fx(2, 2, 0));
    q.push_back(fx(1, 2, 0));
    q.push_back(fx(2, 3, 0));
    q.push_back(fx(1, 3, 0));
    q.push_back(fx(2, 4, 16'h6001));
`ifdef CONTROL_UNIT_JUMP_EN
    q.push_back(fx(9, 4, 16'h6001));
    q.push_back(fx(0, 1, 16'h6001));
    q.push_back(fx(1, 1, 16'h6001));
    q.push_back(fx(2, 2, 0));
`else
    q.push_back(fx(1, 4, 16'h6001));
    q.push_back(fx(2, 5, 16'h5000));
    q.push_back(fx(8, 5, 16'h5000));
`endif
    n = q.size();
    for (int i = 0; i < n; i++) begin
      @(posedge Clk); #1;
      e = q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL jump c%0d: got %h want %h", i, obs, e);
      end
    end
  endtask

  task automatic test_pc_wrap();
    clear_rom();
    do_reset();
    for (int k = 1; k <= 256; k++)
      q.push_back((k % 2) == 1 ? fx(1, ((k - 1) / 2) % 128, 0) : fx(2, (k / 2) % 128, 0));
    for (int i = 0; i < 256; i++) begin
      @(posedge Clk); #1;
      e = q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL pc_wrap c%0d: got %h want %h", i, obs, e);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    clear_rom();
    rom[0] = 16'h2C06;
    do_reset();
    q.push_back(fx(1, 0, 0));
    q.push_back(fx(2, 1, 16'h2C06));
    q.push_back(ex(3, 1, 16'h2C06, 6, 0, 1, 0, 0, 0, 0, 12));
    q.push_back(fx(0, 0, 0));
    q.push_back(fx(1, 0, 0));
    q.push_back(fx(2, 1, 16'h2C06));
    for (int i = 0; i < 6; i++) begin
      @(posedge Clk); #1;
      e = q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reset_mid c%0d: got %h want %h", i, obs, e);
      end
      if (i == 2) Rst = 1'b1;
      if (i == 3) Rst = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_add_sub();
    test_store_halt();
    test_jump();
    test_pc_wrap();
    test_reset_mid_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
